bram_sdp_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_pkg.sv | 36 +++
 rtl/fifo_skid2.sv | 56 +++++
 rtl/bram_sdp_fifo_ctrl.sv | 136 +++++++++++++
 tb/tb_bram_sdp_fifo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for FIFOs built on the SDP block RAM.
// Latency: n/a (elaboration-time only).
// Backpressure: n/a.
package bram_fifo_pkg;

  localparam int BRAM_ADDR_W   = 14;
  localparam int N_LEGAL_DBITS = 7;
  localparam int LEGAL_DBITS [N_LEGAL_DBITS] = '{1, 2, 4, 8, 9, 16, 18};

  // True when the data width maps onto one of the BRAM port modes.
  function automatic bit dbits_legal(input int dbits);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_DBITS; i++) begin
      if (LEGAL_DBITS[i] == dbits) ok = 1'b1;
    end
    return ok;
  endfunction

  // Number of low BRAM address bits consumed by the word width.
  function automatic int mode_shift(input int dbits);
    case (dbits)
      1:       return 0;
      2:       return 1;
      4:       return 2;
      8, 9:    return 3;
      16, 18:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int max_abits(input int dbits);
    return BRAM_ADDR_W - mode_shift(dbits);
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry first-word-fall-through holding buffer; head is entry 0.
// Latency: a pushed word is visible on head the cycle after the push.
// Backpressure: none internally; the caller must never push when full.
module fifo_skid2 #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [1:0]    occ_q;

  assign occ  = occ_q;
  assign head = d0;

  // Shift/fill the two entries; the head keeps its last value when emptied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0    <= '0;
      d1    <= '0;
      occ_q <= 2'd0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) d0 <= din;
          else               d1 <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) d0 <= d1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            d0 <= din;
          end else begin
            d0 <= d1;
            d1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_sdp_fifo_ctrl.sv
// Push/pop FIFO controller for a simple-dual-port BRAM (write B1, read A1) with FWFT output.
// Latency: a push in cycle t shows on DOUT/DVALID in cycle t+3; sustains one pop per cycle.
// Backpressure: FULL refuses pushes (OVERFLOW is sticky); pop while empty sets UNDERFLOW.
module bram_sdp_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int CFG_ABITS    = 10,
  parameter int CFG_DBITS    = 18,
  parameter int CFG_ENABLE_B = 2,
  parameter int AF_TH        = (1 << CFG_ABITS) - 4,
  parameter int AE_TH        = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    PUSH,
  input  logic [CFG_DBITS-1:0]    DIN,
  input  logic                    POP,
  output logic [CFG_DBITS-1:0]    DOUT,
  output logic                    DVALID,
  output logic                    FULL,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [CFG_ABITS+1:0]    COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW,
  output logic [CFG_ABITS-1:0]    B1ADDR,
  output logic [CFG_DBITS-1:0]    B1DATA,
  output logic [CFG_ENABLE_B-1:0] B1EN,
  output logic [CFG_ABITS-1:0]    A1ADDR,
  output logic                    A1EN,
  input  logic [CFG_DBITS-1:0]    A1DATA
);

  localparam int DEPTH = 1 << CFG_ABITS;
  localparam int PW    = CFG_ABITS + 1;
  localparam int CW    = CFG_ABITS + 2;

  if (!dbits_legal(CFG_DBITS)) begin : g_bad_dbits
    $error("bram_sdp_fifo_ctrl: CFG_DBITS=%0d is not a BRAM port width", CFG_DBITS);
  end
  if (CFG_ABITS > max_abits(CFG_DBITS)) begin : g_bad_abits
    $error("bram_sdp_fifo_ctrl: CFG_ABITS=%0d too deep for width %0d", CFG_ABITS, CFG_DBITS);
  end
  if (AF_TH > DEPTH + 2) begin : g_bad_af
    $error("bram_sdp_fifo_ctrl: AF_TH=%0d exceeds the maximum COUNT", AF_TH);
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] mem_cnt;
  logic          inf_q;
  logic [1:0]    occ;
  logic [2:0]    pend;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          af_q;
  logic          ae_q;
  logic          ovf_q;
  logic          unf_q;
  logic          push_acc;
  logic          pop_acc;
  logic          rd_issue;

  // Occupancy terms: words in BRAM, in the read pipe, and in the skid.
  assign mem_cnt = wptr - rptr;
  assign FULL    = (mem_cnt == PW'(DEPTH));
  assign DVALID  = (occ != 2'd0);
  assign pop_acc = POP && DVALID;
  assign pend    = 3'(occ) + 3'(inf_q);

  // RST gating keeps the BRAM ports quiet while reset is held.
  assign push_acc = PUSH && !FULL && !FLUSH && !RST;
  assign rd_issue = (mem_cnt != '0) && (pend <= 3'd1 + 3'(pop_acc)) && !FLUSH && !RST;

  assign B1EN   = {CFG_ENABLE_B{push_acc}};
  assign B1ADDR = wptr[CFG_ABITS-1:0];
  assign B1DATA = push_acc ? DIN : '0;
  assign A1EN   = rd_issue;
  assign A1ADDR = rptr[CFG_ABITS-1:0];

  // Each stage move keeps the total constant, so only push/pop change COUNT.
  assign count_nxt = FLUSH ? '0 : (count_q + CW'(push_acc) - CW'(pop_acc));

  assign COUNT        = count_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

  // Pointer, in-flight, count and sticky-flag state; flush beats everything but reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      inf_q   <= 1'b0;
      count_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      af_q    <= (count_nxt >= CW'(AF_TH));
      ae_q    <= (count_nxt <= CW'(AE_TH));
      if (FLUSH) begin
        wptr  <= '0;
        rptr  <= '0;
        inf_q <= 1'b0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (push_acc) wptr <= wptr + PW'(1);
        if (rd_issue) rptr <= rptr + PW'(1);
        inf_q <= rd_issue;
        if (PUSH && FULL) ovf_q <= 1'b1;
        if (POP && !DVALID) unf_q <= 1'b1;
      end
    end
  end

  // Read data lands in the skid the cycle after issue unless a flush discards it.
  fifo_skid2 #(
    .DW (CFG_DBITS)
  ) u_skid (
    .clk   (CLK),
    .rst   (RST),
    .flush (FLUSH),
    .push  (inf_q && !FLUSH),
    .din   (A1DATA),
    .pop   (pop_acc),
    .occ   (occ),
    .head  (DOUT)
  );

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// Bench for bram_sdp_fifo_ctrl with a behavioural BRAM on the A1/B1 ports.
// Latency: n/a.
// Backpressure: n/a.
module tb_bram_sdp_fifo_ctrl;

  localparam int ABITS = 4;
  localparam int DBITS = 18;
  localparam int ENB   = 2;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              FLUSH;
  logic              PUSH;
  logic [DBITS-1:0]  DIN;
  logic              POP;
  logic [DBITS-1:0]  DOUT;
  logic              DVALID;
  logic              FULL;
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;
  logic [ABITS+1:0]  COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic [ABITS-1:0]  B1ADDR;
  logic [DBITS-1:0]  B1DATA;
  logic [ENB-1:0]    B1EN;
  logic [ABITS-1:0]  A1ADDR;
  logic              A1EN;
  logic [DBITS-1:0]  A1DATA;

  always #5 CLK = ~CLK;

  bram_sdp_fifo_ctrl #(
    .CFG_ABITS    (ABITS),
    .CFG_DBITS    (DBITS),
    .CFG_ENABLE_B (ENB),
    .AF_TH        (AFT),
    .AE_TH        (AET)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .FLUSH        (FLUSH),
    .PUSH         (PUSH),
    .DIN          (DIN),
    .POP          (POP),
    .DOUT         (DOUT),
    .DVALID       (DVALID),
    .FULL         (FULL),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW),
    .B1ADDR       (B1ADDR),
    .B1DATA       (B1DATA),
    .B1EN         (B1EN),
    .A1ADDR       (A1ADDR),
    .A1EN         (A1EN),
    .A1DATA       (A1DATA)
  );

  // Simple-dual-port BRAM: synchronous write on B1, one-cycle read on A1.
  logic [DBITS-1:0] bram [DEPTH];
  always @(posedge CLK) begin
    if (B1EN == 2'b11) bram[B1ADDR] <= B1DATA;
    if (A1EN) A1DATA <= bram[A1ADDR];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic             push;
    logic [DBITS-1:0] din;
    logic             pop;
    logic             a1en;
    logic             b1en;
    logic             dvalid;
    logic [DBITS-1:0] dout;
    int               count;
    logic             ae;
    logic             unf;
  } vec_t;
  vec_t tbl [10];

  typedef struct {
    logic [DBITS-1:0] d;
    int               t;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    PUSH  = 1'b0;
    POP   = 1'b0;
    FLUSH = 1'b0;
    DIN   = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    tick();
  endtask

  function automatic vec_t mk(input int push, input int din, input int pop, input int a1en,
                              input int b1en, input int dv, input int dout, input int count,
                              input int ae, input int unf);
    vec_t v;
    v.push = push[0];   v.din = DBITS'(din); v.pop = pop[0];  v.a1en = a1en[0];
    v.b1en = b1en[0];   v.dvalid = dv[0];    v.dout = DBITS'(dout);
    v.count = count;    v.ae = ae[0];        v.unf = unf[0];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int first_pop;
    int last_pop;
    logic full_seen;
    logic exp_dv;
    logic unf_m;

    RST = 1'b1;
    idle_inputs();

    // ---- reset asserted mid-stream with five words held ----
    do_reset();
    for (int c = 0; c < 5; c++) begin
      PUSH = 1'b1; DIN = DBITS'(32'h11 + c);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    @(negedge CLK);
    chk("pre_rst_count", 32'(COUNT), 5);
    chk("pre_rst_dvalid", 32'(DVALID), 1);
    PUSH = 1'b1; DIN = '1; POP = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst_async_count", 32'(COUNT), 0);
    chk("rst_async_dvalid", 32'(DVALID), 0);
    chk("rst_async_dout", 32'(DOUT), 0);
    chk("rst_async_flags", 32'({FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW}), 0);
    chk("rst_async_bram", 32'({B1EN, B1ADDR, A1EN, A1ADDR}), 0);
    chk("rst_async_b1data", 32'(B1DATA), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    chk("post_rst_count", 32'(COUNT), 0);
    chk("post_rst_dvalid", 32'(DVALID), 0);
    tick();
    @(negedge CLK);
    chk("post_rst_count2", 32'(COUNT), 0);
    chk("post_rst_dvalid2", 32'(DVALID), 0);
    chk("post_rst_ae", 32'(ALMOST_EMPTY), 1);

    // ---- first-word latency, drain, and pop while empty (table) ----
    tbl[0] = mk(1, 1, 0,  0, 1, 0, 0, 0, 1, 0);
    tbl[1] = mk(1, 2, 0,  1, 1, 0, 0, 1, 1, 0);
    tbl[2] = mk(1, 3, 0,  1, 1, 0, 0, 2, 1, 0);
    tbl[3] = mk(0, 0, 0,  0, 0, 1, 1, 3, 0, 0);
    tbl[4] = mk(0, 0, 0,  0, 0, 1, 1, 3, 0, 0);
    tbl[5] = mk(0, 0, 1,  1, 0, 1, 1, 3, 0, 0);
    tbl[6] = mk(0, 0, 1,  0, 0, 1, 2, 2, 1, 0);
    tbl[7] = mk(0, 0, 1,  0, 0, 1, 3, 1, 1, 0);
    tbl[8] = mk(0, 0, 1,  0, 0, 0, 3, 0, 1, 0);
    tbl[9] = mk(0, 0, 0,  0, 0, 0, 3, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      PUSH = tbl[i].push; DIN = tbl[i].din; POP = tbl[i].pop; FLUSH = 1'b0;
      @(negedge CLK);
      chk("tbl_a1en", 32'(A1EN), 32'(tbl[i].a1en));
      chk("tbl_b1en", 32'(B1EN), tbl[i].b1en ? 32'd3 : 32'd0);
      chk("tbl_dvalid", 32'(DVALID), 32'(tbl[i].dvalid));
      chk("tbl_dout", 32'(DOUT), 32'(tbl[i].dout));
      chk("tbl_count", 32'(COUNT), tbl[i].count);
      chk("tbl_ae", 32'(ALMOST_EMPTY), 32'(tbl[i].ae));
      chk("tbl_unf", 32'(UNDERFLOW), 32'(tbl[i].unf));
      tick();
    end
    idle_inputs();

    // ---- 40-word stream with POP = DVALID ----
    do_reset();
    k = 0; first_pop = -1; last_pop = -1; full_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      PUSH = (c < 40); DIN = DBITS'(c); POP = DVALID;
      @(negedge CLK);
      if (FULL) full_seen = 1'b1;
      if (POP) begin
        chk("stream_dout", 32'(DOUT), k);
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        k++;
      end
      tick();
    end
    idle_inputs();
    chk("stream_first_pop", first_pop, 3);
    chk("stream_last_pop", last_pop, 42);
    chk("stream_pops", k, 40);
    chk("stream_full_seen", 32'(full_seen), 0);

    // ---- fill to full, overflow, drain ----
    do_reset();
    for (int c = 0; c < 20; c++) begin
      PUSH = (c < 19); DIN = DBITS'(100 + c); POP = 1'b0;
      @(negedge CLK);
      chk("fill_count", 32'(COUNT), (c < 18) ? c : 18);
      chk("fill_full", 32'(FULL), 32'(c >= 18));
      chk("fill_af", 32'(ALMOST_FULL), 32'(c >= 14));
      chk("fill_b1en", 32'(B1EN), (c < 18) ? 32'd3 : 32'd0);
      chk("fill_ovf", 32'(OVERFLOW), 32'(c >= 19));
      tick();
    end
    idle_inputs();
    k = 0;
    for (int c = 0; c < 60 && k < 18; c++) begin
      POP = DVALID;
      @(negedge CLK);
      if (POP) begin
        chk("drain_dout", 32'(DOUT), 100 + k);
        k++;
      end
      tick();
    end
    POP = 1'b0;
    chk("drain_words", k, 18);
    @(negedge CLK);
    chk("drain_count", 32'(COUNT), 0);
    chk("drain_ovf_sticky", 32'(OVERFLOW), 1);
    tick();

    // ---- flush against an in-flight read, with a same-cycle push ----
    do_reset();
    PUSH = 1'b1; DIN = 18'h155; POP = 1'b1;
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("fl_a1en", 32'(A1EN), 1);
    chk("fl_unf_before", 32'(UNDERFLOW), 1);
    tick();
    FLUSH = 1'b1; PUSH = 1'b1; DIN = 18'h2AA;
    @(negedge CLK);
    chk("fl_b1en", 32'(B1EN), 0);
    chk("fl_count_before", 32'(COUNT), 1);
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("fl_count", 32'(COUNT), 0);
    chk("fl_dvalid", 32'(DVALID), 0);
    chk("fl_unf", 32'(UNDERFLOW), 0);
    chk("fl_ovf", 32'(OVERFLOW), 0);
    repeat (3) tick();
    @(negedge CLK);
    chk("fl_dvalid_later", 32'(DVALID), 0);
    chk("fl_count_later", 32'(COUNT), 0);
    chk("fl_a1en_later", 32'(A1EN), 0);
    tick();

    // ---- randomized traffic against a queue model ----
    do_reset();
    q.delete();
    unf_m = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      exp_dv = (q.size() > 0) && (cyc >= q[0].t + 3);
      FLUSH  = ($urandom_range(63) == 0);
      PUSH   = (q.size() < DEPTH - 2) && ($urandom_range(2) != 0);
      DIN    = DBITS'($urandom);
      POP    = exp_dv ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
      @(negedge CLK);
      chk("rnd_dvalid", 32'(DVALID), 32'(exp_dv));
      if (exp_dv) chk("rnd_dout", 32'(DOUT), 32'(q[0].d));
      chk("rnd_count", 32'(COUNT), q.size());
      chk("rnd_af", 32'(ALMOST_FULL), 32'(q.size() >= AFT));
      chk("rnd_ae", 32'(ALMOST_EMPTY), 32'(q.size() <= AET));
      chk("rnd_unf", 32'(UNDERFLOW), 32'(unf_m));
      chk("rnd_ovf_full", 32'({OVERFLOW, FULL}), 0);
      chk("rnd_b1en", 32'(B1EN), (PUSH && !FLUSH) ? 32'd3 : 32'd0);
      if (FLUSH) begin
        q.delete();
        unf_m = 1'b0;
      end else begin
        if (POP) begin
          if (exp_dv) void'(q.pop_front());
          else        unf_m = 1'b1;
        end
        if (PUSH) q.push_back('{DIN, cyc});
      end
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
